cache_assoc_controller: RTL and testbench

Miss-handling controller for the N-way set-associative, write-back / write-allocate data cache. It replaces the fixed-latency direct-mapped controller. Memory beats use a ready handshake instead of a fixed wait count, and victim selection uses tree pseudo-LRU kept per set. It sits between the processor-facing cache top and the per-way set/line arrays, and it drives the memory port for line refill and write-back.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_plru.sv | 68 ++++++
 rtl/cache_assoc_controller.sv | 162 ++++++++++++++++
 tb/tb_cache_assoc_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache miss controller.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      READ_MEM   = 2'd2
   } state_t;

   localparam int CTRL_WRITE_EN    = 5;
   localparam int CTRL_SET_VALID   = 4;
   localparam int CTRL_SET_DIRTY   = 3;
   localparam int CTRL_STRATEGY_EN = 2;
   localparam int CTRL_OFFSET_SEL  = 1;
   localparam int CTRL_MEM_WE      = 0;

   function automatic int line_size(input int offset_width);
      return 1 << (offset_width - 2);
   endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU: victim lookup for one index, MRU update for another.
module cache_plru #(
   parameter int SET_WIDTH = 2,
   parameter int NUM_WAYS  = 4,
   parameter int WAY_WIDTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [SET_WIDTH-1:0] lookup_index,
   output logic [WAY_WIDTH-1:0] victim_way,
   input  logic                 update_en,
   input  logic [SET_WIDTH-1:0] update_index,
   input  logic [WAY_WIDTH-1:0] update_way
);

   localparam int LEVELS   = $clog2(NUM_WAYS);
   localparam int NUM_SETS = 2 ** SET_WIDTH;

   generate
      if (NUM_WAYS == 1) begin : g_direct
         logic unused_plru;
         assign unused_plru = ^{clk_i, rst_ni, lookup_index, update_en, update_index, update_way};
         assign victim_way  = '0;
      end else begin : g_tree
         // Level l of the tree decides way bit l; its node is picked by the way bits below l.
         localparam logic [NUM_WAYS-2:0] ONE = 1;
         logic [NUM_WAYS-2:0] tree_q [NUM_SETS];
         logic [NUM_WAYS-2:0] lookup_bits;
         logic [NUM_WAYS-2:0] update_bits;

         assign lookup_bits = tree_q[lookup_index];

         always_comb begin
            int v;
            int node;
            logic [NUM_WAYS-2:0] sh;
            v = 0;
            for (int l = 0; l < LEVELS; l++) begin
               node = (1 << l) - 1 + v;
               sh   = lookup_bits >> node;
               if (sh[0]) v = v | (1 << l);
            end
            victim_way = WAY_WIDTH'(v);
         end

         always_comb begin
            int w;
            int node;
            update_bits = tree_q[update_index];
            w = int'(update_way);
            for (int l = 0; l < LEVELS; l++) begin
               node = (1 << l) - 1 + (w & ((1 << l) - 1));
               if (((w >> l) & 1) == 1) update_bits = update_bits & ~(ONE << node);
               else                     update_bits = update_bits | (ONE << node);
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
            end else if (update_en) begin
               tree_q[update_index] <= update_bits;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/cache_assoc_controller.sv
// Miss-handling controller: write-back of a dirty victim, then line refill, with ready-handshaked beats.
//
// state      | meaning
// IDLE       | serve hits in zero wait; on a miss latch victim and pick next phase
// WRITE_BACK | stream dirty victim line out to memory, one beat per ready
// READ_MEM   | refill line from memory into the victim way, set_valid on last beat
module cache_assoc_controller
   import cache_pkg::*;
#(
   parameter int TAG_WIDTH    = 26,
   parameter int SET_WIDTH    = 2,
   parameter int OFFSET_WIDTH = 4,
   parameter int NUM_WAYS     = 4,
   parameter int WAY_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    en_i,
   input  logic                    write_en_i,
   input  logic [31:0]             addr_i,
   input  logic                    hit_i,
   input  logic [WAY_WIDTH-1:0]    hit_way_i,
   input  logic                    dirty_i,
   input  logic [TAG_WIDTH-1:0]    tag_line_i,
   input  logic                    mem_ready_i,
   output logic [5:0]              control_o,
   output logic [WAY_WIDTH-1:0]    way_sel_o,
   output logic                    mem_req_o,
   output logic [31:0]             mem_addr_o,
   output logic [OFFSET_WIDTH-3:0] offset_line_o,
   output logic                    stall_o
);

   localparam int BEAT_W = OFFSET_WIDTH - 2;
   localparam int LINE   = line_size(OFFSET_WIDTH);

   state_t                 state_q;
   logic [BEAT_W-1:0]      beat_q;
   logic [WAY_WIDTH-1:0]   victim_way_q;
   logic [TAG_WIDTH-1:0]   victim_tag_q;
   logic [TAG_WIDTH-1:0]   miss_tag_q;
   logic [SET_WIDTH-1:0]   miss_index_q;

   logic [SET_WIDTH-1:0]   addr_index;
   logic [TAG_WIDTH-1:0]   addr_tag;
   logic [WAY_WIDTH-1:0]   plru_victim;
   logic                   plru_update_en;
   logic [SET_WIDTH-1:0]   plru_update_index;
   logic [WAY_WIDTH-1:0]   plru_update_way;
   logic                   last_beat;
   logic                   miss;
   logic                   unused_offset;

   assign addr_index    = addr_i[OFFSET_WIDTH +: SET_WIDTH];
   assign addr_tag      = addr_i[31 -: TAG_WIDTH];
   assign unused_offset = ^addr_i[OFFSET_WIDTH-1:0];
   assign last_beat     = (beat_q == BEAT_W'(LINE - 1));
   assign miss          = (state_q == IDLE) && en_i && !hit_i;

   // A hit in IDLE and the completed refill are the only events that touch recency.
   assign plru_update_en    = ((state_q == IDLE) && en_i && hit_i) ||
                              ((state_q == READ_MEM) && mem_ready_i && last_beat);
   assign plru_update_index = (state_q == IDLE) ? addr_index : miss_index_q;
   assign plru_update_way   = (state_q == IDLE) ? hit_way_i  : victim_way_q;

   cache_plru #(
      .SET_WIDTH (SET_WIDTH),
      .NUM_WAYS  (NUM_WAYS),
      .WAY_WIDTH (WAY_WIDTH)
   ) u_plru (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .lookup_index (addr_index),
      .victim_way   (plru_victim),
      .update_en    (plru_update_en),
      .update_index (plru_update_index),
      .update_way   (plru_update_way)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         victim_way_q <= '0;
         victim_tag_q <= '0;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss) begin
                  victim_way_q <= plru_victim;
                  victim_tag_q <= tag_line_i;
                  miss_tag_q   <= addr_tag;
                  miss_index_q <= addr_index;
                  beat_q       <= '0;
                  state_q      <= dirty_i ? WRITE_BACK : READ_MEM;
               end
            end
            WRITE_BACK: begin
               if (mem_ready_i) begin
                  if (last_beat) begin
                     beat_q  <= '0;
                     state_q <= READ_MEM;
                  end else begin
                     beat_q  <= beat_q + 1'b1;
                  end
               end
            end
            READ_MEM: begin
               if (mem_ready_i) begin
                  if (last_beat) begin
                     beat_q  <= '0;
                     state_q <= IDLE;
                  end else begin
                     beat_q  <= beat_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      control_o     = '0;
      way_sel_o     = plru_victim;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      offset_line_o = beat_q;
      stall_o       = (state_q != IDLE) || (en_i && !hit_i);
      case (state_q)
         IDLE: begin
            if (en_i && hit_i) begin
               control_o[CTRL_WRITE_EN]    = write_en_i;
               control_o[CTRL_SET_DIRTY]   = write_en_i;
               control_o[CTRL_STRATEGY_EN] = 1'b1;
               control_o[CTRL_OFFSET_SEL]  = 1'b1;
               way_sel_o                   = hit_way_i;
            end
         end
         WRITE_BACK: begin
            mem_req_o              = 1'b1;
            control_o[CTRL_MEM_WE] = 1'b1;
            way_sel_o              = victim_way_q;
            mem_addr_o             = {victim_tag_q, miss_index_q, beat_q, 2'b00};
         end
         READ_MEM: begin
            mem_req_o  = 1'b1;
            way_sel_o  = victim_way_q;
            mem_addr_o = {miss_tag_q, miss_index_q, beat_q, 2'b00};
            if (mem_ready_i) begin
               control_o[CTRL_WRITE_EN]    = 1'b1;
               control_o[CTRL_STRATEGY_EN] = 1'b1;
               control_o[CTRL_SET_VALID]   = last_beat;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_assoc_controller.sv
// Directed bench for the miss controller: refill, write-back, ready stalls, PLRU order, mid-phase reset.
module tb_cache_assoc_controller;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i, write_en_i, hit_i, dirty_i, mem_ready_i;
   logic [31:0] addr_i;
   logic [1:0]  hit_way_i;
   logic [25:0] tag_line_i;
   logic [5:0]  control_o;
   logic [1:0]  way_sel_o;
   logic        mem_req_o, stall_o;
   logic [31:0] mem_addr_o;
   logic [1:0]  offset_line_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   cache_assoc_controller #(
      .TAG_WIDTH(26), .SET_WIDTH(2), .OFFSET_WIDTH(4), .NUM_WAYS(4), .WAY_WIDTH(2)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .write_en_i(write_en_i),
      .addr_i(addr_i), .hit_i(hit_i), .hit_way_i(hit_way_i), .dirty_i(dirty_i),
      .tag_line_i(tag_line_i), .mem_ready_i(mem_ready_i), .control_o(control_o),
      .way_sel_o(way_sel_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .offset_line_o(offset_line_o), .stall_o(stall_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // One memory phase with ready held high; the state machine advances one beat per cycle.
   task automatic burst(input string tag, input logic [31:0] base, input logic is_write,
                        input logic [1:0] way);
      mem_ready_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk({tag, "_req"},  {31'd0, mem_req_o}, 32'd1);
         chk({tag, "_addr"}, mem_addr_o, base + 32'(4 * b));
         chk({tag, "_off"},  {30'd0, offset_line_o}, 32'(b));
         chk({tag, "_way"},  {30'd0, way_sel_o}, {30'd0, way});
         chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
         if (is_write)    chk({tag, "_ctrl"}, {26'd0, control_o}, 32'b000001);
         else if (b == 3) chk({tag, "_ctrl"}, {26'd0, control_o}, 32'b110100);
         else             chk({tag, "_ctrl"}, {26'd0, control_o}, 32'b100100);
         tick();
      end
   endtask

   task automatic access(input logic [31:0] addr, input logic we, input logic hit,
                         input logic [1:0] hway, input logic dirty, input logic [25:0] vtag);
      en_i = 1'b1; write_en_i = we; addr_i = addr; hit_i = hit;
      hit_way_i = hway; dirty_i = dirty; tag_line_i = vtag;
   endtask

   initial begin
      rst_ni = 1'b0; en_i = 1'b0; write_en_i = 1'b0; addr_i = '0; hit_i = 1'b0;
      hit_way_i = '0; dirty_i = 1'b0; tag_line_i = '0; mem_ready_i = 1'b0;
      #12 rst_ni = 1'b1;
      tick();
      #1;
      chk("rst_ctrl",  {26'd0, control_o}, 32'd0);
      chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_way",   {30'd0, way_sel_o}, 32'd0);

      // Clean miss on 0x104 with a 3-cycle ready gap at beat 2.
      access(32'h104, 1'b0, 1'b0, 2'd0, 1'b0, 26'd0);
      #1;
      chk("cm_stall", {31'd0, stall_o}, 32'd1);
      chk("cm_ctrl",  {26'd0, control_o}, 32'd0);
      chk("cm_way",   {30'd0, way_sel_o}, 32'd0);
      tick();
      mem_ready_i = 1'b1;
      for (int b = 0; b < 2; b++) begin
         #1;
         chk("cm_addr", mem_addr_o, 32'h100 + 32'(4 * b));
         chk("cm_ctrl", {26'd0, control_o}, 32'b100100);
         tick();
      end
      mem_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("hold_addr", mem_addr_o, 32'h108);
         chk("hold_ctrl", {26'd0, control_o}, 32'd0);
         chk("hold_off",  {30'd0, offset_line_o}, 32'd2);
         chk("hold_req",  {31'd0, mem_req_o}, 32'd1);
         tick();
      end
      mem_ready_i = 1'b1;
      #1;
      chk("cm_addr2", mem_addr_o, 32'h108);
      chk("cm_ctrl2", {26'd0, control_o}, 32'b100100);
      tick();
      #1;
      chk("cm_addr3", mem_addr_o, 32'h10C);
      chk("cm_last",  {26'd0, control_o}, 32'b110100);
      chk("cm_lway",  {30'd0, way_sel_o}, 32'd0);
      tick();
      hit_i = 1'b1; hit_way_i = 2'd0; mem_ready_i = 1'b0;
      #1;
      chk("cm_hit_stall", {31'd0, stall_o}, 32'd0);
      chk("cm_hit_ctrl",  {26'd0, control_o}, 32'b000110);
      chk("cm_hit_req",   {31'd0, mem_req_o}, 32'd0);
      tick();

      // Dirty store miss in set 1: victim way 0 with tag 0x3, new tag 0x9.
      access(32'h254, 1'b1, 1'b0, 2'd0, 1'b1, 26'h3);
      #1;
      chk("dm_stall", {31'd0, stall_o}, 32'd1);
      chk("dm_way",   {30'd0, way_sel_o}, 32'd0);
      chk("dm_ctrl",  {26'd0, control_o}, 32'd0);
      tick();
      dirty_i = 1'b0; tag_line_i = '0;
      burst("wb", 32'hD0, 1'b1, 2'd0);
      burst("rd", 32'h250, 1'b0, 2'd0);
      hit_i = 1'b1; hit_way_i = 2'd0; mem_ready_i = 1'b0;
      #1;
      chk("dm_hit_ctrl",  {26'd0, control_o}, 32'b101110);
      chk("dm_hit_stall", {31'd0, stall_o}, 32'd0);
      tick();

      // Set 0 hits on ways 0,1,2 leave way 3 as the pseudo-LRU victim.
      for (int w = 0; w < 3; w++) begin
         access(32'h104, 1'b0, 1'b1, 2'(w), 1'b0, 26'd0);
         #1;
         chk("plru_hit_way", {30'd0, way_sel_o}, 32'(w));
         tick();
      end
      access(32'h304, 1'b0, 1'b0, 2'd0, 1'b0, 26'd4);
      #1;
      chk("plru_victim3", {30'd0, way_sel_o}, 32'd3);
      tick();
      burst("rd3", 32'h300, 1'b0, 2'd3);
      hit_i = 1'b1; hit_way_i = 2'd3; mem_ready_i = 1'b0;
      #1;
      chk("rd3_hit_stall", {31'd0, stall_o}, 32'd0);
      tick();

      // Next miss in set 0 picks way 0, dirty; reset lands in write-back beat 1.
      access(32'h404, 1'b0, 1'b0, 2'd0, 1'b1, 26'd4);
      #1;
      chk("plru_victim0", {30'd0, way_sel_o}, 32'd0);
      tick();
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      #1;
      chk("rb_addr", mem_addr_o, 32'h104);
      chk("rb_ctrl", {26'd0, control_o}, 32'b000001);
      rst_ni = 1'b0; en_i = 1'b0;
      #1;
      chk("rb_req",   {31'd0, mem_req_o}, 32'd0);
      chk("rb_ctrl0", {26'd0, control_o}, 32'd0);
      chk("rb_stall", {31'd0, stall_o}, 32'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      access(32'h404, 1'b0, 1'b0, 2'd0, 1'b0, 26'd0);
      #1;
      chk("rb_miss_stall", {31'd0, stall_o}, 32'd1);
      chk("rb_miss_way",   {30'd0, way_sel_o}, 32'd0);
      tick();
      en_i = 1'b0;
      #1;
      chk("rb_refill_req",  {31'd0, mem_req_o}, 32'd1);
      chk("rb_refill_addr", mem_addr_o, 32'h400);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
